// File: rtl/scan_mux_seq.sv
// Registered N-channel x W-bit mux with manual select or masked auto-scan; 1-cycle latency din->O.
// No backpressure: outputs refresh every cycle, strobe marks each auto-scan advance.
module scan_mux_seq #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       mask,
  input  logic                      hold,
  output logic [WIDTH-1:0]          O,
  output logic [SEL_W-1:0]          cur_sel,
  output logic [CHANNELS-1:0]       chan_en,
  output logic                      strobe
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int IW = SEL_W + 1;
  localparam logic [IW-1:0] NCH      = IW'(CHANNELS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  logic [CW-1:0]       cnt, cnt_next;
  logic [SEL_W-1:0]    next_sel, found_sel, base;
  logic [IW-1:0]       probe;
  logic                found, cur_ok, valid_next, strobe_next;
  logic [WIDTH-1:0]    sel_dat;
  logic [CHANNELS-1:0] sel_onehot;

  // First enabled channel after cur_sel, wrapping; an out-of-range cur_sel searches from 0.
  always_comb begin
    base      = ({1'b0, cur_sel} < NCH) ? cur_sel : SEL_W'(CHANNELS - 1);
    found     = 1'b0;
    found_sel = base;
    probe     = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      probe = {1'b0, base} + IW'(k);
      if (probe >= NCH) probe = probe - NCH;
      if (!found && mask[probe[SEL_W-1:0]]) begin
        found     = 1'b1;
        found_sel = probe[SEL_W-1:0];
      end
    end
  end

  assign cur_ok = ({1'b0, cur_sel} < NCH) && mask[cur_sel];

  always_comb begin
    next_sel    = cur_sel;
    valid_next  = 1'b0;
    cnt_next    = '0;
    strobe_next = 1'b0;
    if (!mode) begin
      next_sel   = sel;
      valid_next = ({1'b0, sel} < NCH);
    end else if (mask == '0) begin
      next_sel = cur_sel;
    end else if (hold) begin
      cnt_next   = cnt;
      valid_next = cur_ok;
    end else if (!cur_ok || cnt == CNT_LAST) begin
      next_sel    = found_sel;
      valid_next  = 1'b1;
      strobe_next = 1'b1;
    end else begin
      cnt_next   = cnt + CW'(1);
      valid_next = 1'b1;
    end
  end

  always_comb begin
    sel_dat    = '0;
    sel_onehot = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (next_sel == SEL_W'(i)) begin
        sel_dat       = din[i*WIDTH +: WIDTH];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      O       <= '0;
      cur_sel <= '0;
      chan_en <= '0;
      strobe  <= 1'b0;
      cnt     <= '0;
    end else begin
      cur_sel <= next_sel;
      O       <= valid_next ? sel_dat : '0;
      chan_en <= valid_next ? sel_onehot : '0;
      strobe  <= strobe_next;
      cnt     <= cnt_next;
    end
  end

endmodule

// File: doc/scan_mux_seq.md
Name: scan_mux_seq

Overview:
- Parametrised, registered N-channel by W-bit multiplexer for the processor datapath and display path.
- Generalises the fixed 8x1 4-bit select mux in two ways: width and channel count are parameters, and the output is registered.
- Adds an auto-scan mode that cycles through channels, dwelling a programmable number of cycles on each.
- Supports a per-channel enable mask, a hold control, a one-hot channel enable and a channel-change strobe.

Parameters:
- WIDTH, 4: data bits per channel.
- CHANNELS, 8: number of input channels. Must be at least 2.
- SEL_W, 3: select width. Must satisfy 2**SEL_W >= CHANNELS.
- DWELL, 4: cycles spent on each channel in auto mode. Must be at least 1.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- din, input, CHANNELS*WIDTH: packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- mode, input, 1: 0 = manual select, 1 = auto scan.
- sel, input, SEL_W: channel select used in manual mode.
- mask, input, CHANNELS: auto-mode channel enables; bit i enables channel i.
- hold, input, 1: auto mode only; freezes the scan position.
- O, output, WIDTH: registered selected data.
- cur_sel, output, SEL_W: channel currently driving O.
- chan_en, output, CHANNELS: one-hot of cur_sel while valid, else 0.
- strobe, output, 1: one-cycle pulse when auto scan advances.

Behaviour:
- Reset, checked at the clock edge and overriding all inputs:
  - O=0, cur_sel=0, chan_en=0, strobe=0, dwell counter=0.
  - Reset mid-scan discards all scan position.
- Every cycle the block computes next_sel and valid_next, then registers:
  - cur_sel<=next_sel
  - O<=din[next_sel] if valid_next, else 0
  - chan_en<=onehot(next_sel) if valid_next, else 0
  - Latency: O tracks din with 1 cycle of delay. O, cur_sel and chan_en always update on the same edge.
- Manual mode (mode=0):
  - next_sel=sel; the mask is ignored.
  - sel>=CHANNELS: valid_next=0, so O=0 and chan_en=0. There is no default-to-last-channel behaviour.
  - Dwell counter held at 0; strobe=0.
- Auto mode (mode=1):
  - Dwell counter counts 0..DWELL-1 while on a valid channel.
  - Advance when counter==DWELL-1 and hold=0:
    - next_sel = first channel with its mask bit set, searching cur_sel+1 upward and wrapping modulo CHANNELS.
    - Counter returns to 0.
    - strobe=1 on the same edge that cur_sel updates.
  - Only cur_sel enabled: the search wraps back to cur_sel, the channel does not change, and strobe still pulses every DWELL cycles.
  - DWELL=1: advance every cycle.
  - hold=1:
    - Counter and cur_sel frozen; no strobe.
    - O keeps refreshing from din[cur_sel].
    - If mask[cur_sel] is cleared while hold=1, O=0 and chan_en=0 until hold is released.
  - Current channel masked off mid-dwell with hold=0:
    - Advance on the next edge regardless of the counter.
    - Counter returns to 0; strobe=1.
  - mask all zero:
    - valid_next=0, so O=0 and chan_en=0.
    - cur_sel holds its value; counter held at 0; strobe=0.
  - mask becomes nonzero again: advance on the next edge using the normal search.
- Mode changes:
  - Manual to auto: scan resumes from the current cur_sel, counter at 0. If that channel is masked, advance on the next edge.
  - Auto to manual: cur_sel=sel on the next edge; counter cleared; no strobe.
- Output encoding:
  - chan_en is never multi-hot.
  - cur_sel is always less than CHANNELS, except in manual mode with an out-of-range sel.
- Width rules:
  - Counter width is clog2(DWELL), minimum 1 bit.
  - The wrap search is combinational over CHANNELS entries; there is no multi-cycle search.

Test Plan:
Common setup: WIDTH=4, CHANNELS=8, DWELL=3, channel i data = i+1.
1. Reset, then mode=0 with sel stepped 0..7, then sel=0 with channel 0 data changed to 4'hA -> O lags by 1 cycle with values 1..8, then 4'hA one cycle after the data change; chan_en=8'h01..8'h80.
2. mode=1, mask=8'hFF, hold=0 -> cur_sel steps 0,1,...,7,0 every 3 cycles; strobe pulses once per step; O=cur_sel+1.
3. mode=1, mask=8'b1010_0100 starting at cur_sel=0 -> visit order 2,5,7,2; channel 0 masked so first advance occurs next cycle; O = 3,6,8,3.
4. Auto scan running; hold=1 for 10 cycles, then mask[cur_sel] cleared while holding -> no strobe, cur_sel frozen, O=0, chan_en=0; release hold -> advance next edge with strobe.
5. mask=0 in auto -> O=0, chan_en=0, strobe=0 with cur_sel held; then mask=8'h10 -> cur_sel=4, O=5 after 1 edge.
6. Reset asserted mid-dwell on channel 6, and separately mode=0 with sel=7 then sel out of range (with CHANNELS=6) -> reset gives all outputs 0 next edge and the scan restarts at 0; out-of-range sel gives O=0, chan_en=0.
